mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL provide `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL provide `rstn`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide `A`, input, 32 bits, signed: rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-004 The block SHALL provide `B`, input, 32 bits, signed: rt operand (divisor / multiplier).
REQ-005 The block SHALL provide `MDUOp`, input, 3 bits, with this encoding:
- 000 NOP
- 001 MULT
- 010 MULTU
- 011 DIV
- 100 DIVU
- 101 MTHI
- 110 MTLO
- 111 NOP
REQ-006 The block SHALL provide `start`, input, 1 bit: request qualifier for `MDUOp`, sampled each rising edge.
REQ-007 The block SHALL provide `cancel`, input, 1 bit: abort an in-flight operation (pipeline flush).
REQ-008 The block SHALL provide `busy`, output, 1 bit: high while an iterative operation is running.
REQ-009 The block SHALL provide `HI`, output, 32 bits: high product word or remainder.
REQ-010 The block SHALL provide `LO`, output, 32 bits: low product word or quotient.

Function
REQ-011 The FSM SHALL have two states, IDLE and RUN, plus a 5-bit iteration counter.
REQ-012 In IDLE, `start`=1 with MULT/MULTU/DIV/DIVU at edge k SHALL latch A, B and the op, clear the counter, enter RUN, and raise `busy` from edge k.
REQ-013 RUN SHALL perform exactly one shift-add (multiply) or one restoring-subtract (divide) iteration per cycle, for 32 cycles.
REQ-014 At edge k+32 the block SHALL write HI/LO, drop `busy` and return to IDLE; `busy` is high for exactly 32 cycles.
REQ-015 HI/LO SHALL hold their previous values throughout RUN and change only at completion.
REQ-016 MULT SHALL produce the signed 64-bit product {HI,LO}; MULTU SHALL produce the unsigned product.
REQ-017 DIV SHALL truncate the quotient toward zero, with the remainder taking the sign of the dividend; the divider SHALL operate on magnitudes and fix signs at completion.
REQ-018 DIVU SHALL treat both operands as unsigned.
REQ-019 Divide by zero SHALL still take 32 cycles and SHALL give LO=32'hFFFFFFFF and HI=A (DIV and DIVU alike).
REQ-020 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-021 MTHI/MTLO with `start`=1 in IDLE SHALL write A into HI or LO at that edge, single-cycle, without raising `busy`.
REQ-022 `start` while `busy`=1 SHALL be ignored: no queuing, and operands in flight are unaffected.
REQ-023 `start` with NOP (000/111) SHALL have no effect.
REQ-024 `cancel`=1 at any edge in RUN SHALL return the FSM to IDLE, drop `busy` and leave HI/LO unchanged.
REQ-025 `cancel`=1 in IDLE SHALL be a no-op and SHALL take precedence over a simultaneous `start`.
REQ-026 `start` at the completion edge (k+32) SHALL be ignored; a new operation is accepted from edge k+33.

Reset
REQ-027 `rstn`=0 SHALL immediately, without a clock edge, force IDLE, `busy`=0, HI=0, LO=0 and counter=0.
REQ-028 Reset asserted mid-RUN SHALL discard the operation; after release the block SHALL be idle and accept `start` on the first edge.

Configuration
REQ-029 Macro `MDU_DIV_EN` defined: the divider SHALL be built and DIV/DIVU SHALL behave as in REQ-017 to REQ-020.
REQ-030 `MDU_DIV_EN` undefined: no divider logic SHALL be present, and DIV/DIVU SHALL be treated as NOP (no `busy`, HI/LO unchanged); multiply and MTHI/MTLO SHALL be unaffected.

Verification
REQ-031 MULT A=-3 (32'hFFFFFFFD), B=7 -> `busy` high for 32 cycles, then HI=32'hFFFFFFFF and LO=32'hFFFFFFEB.
REQ-032 MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001; DIVU 100/7 -> LO=14, HI=2.
REQ-033 DIV -7/2 -> LO=-3, HI=-1; DIV 5/0 -> LO=32'hFFFFFFFF, HI=5; DIV 32'h80000000/-1 -> LO=32'h80000000, HI=0.
REQ-034 MTHI A=32'h12345678 -> HI updates at that edge with `busy`=0; MTLO while `busy` is high -> LO unchanged.
REQ-035 Start MULT, `cancel` at cycle 10 -> `busy` low next edge, HI/LO keep prior values; start DIV, `rstn` low at cycle 5 -> HI=LO=0, `busy`=0 without a clock edge.
REQ-036 Build without `MDU_DIV_EN`, issue DIV 9/3 -> `busy` stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/mdu.sv
// mdu -- iterative multiply/divide unit with HI/LO result registers.
//
// Multiplies (MULT/MULTU) use a 32-step shift-add and divides (DIV/DIVU) use
// a 32-step restoring subtract. Each step takes one clock. Both operate on
// operand magnitudes, and the result signs are fixed when the operation
// completes. MTHI/MTLO copy A into HI or LO in a single cycle.
//
// Build option:
//   MDU_DIV_EN  defined   -> the divider is built and DIV/DIVU are executed
//               undefined -> no divider logic; DIV/DIVU behave as NOP
//
// Ports:
//   clk     in   clock, rising edge
//   rstn    in   asynchronous active-low reset
//   A       in   32b rs operand (dividend / multiplicand / MTHI-MTLO source)
//   B       in   32b rt operand (divisor / multiplier)
//   MDUOp   in   3b op: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                101 MTHI, 110 MTLO, 000/111 NOP
//   start   in   qualifies MDUOp
//   cancel  in   aborts a running operation; HI/LO stay unchanged
//   busy    out  high while an iterative operation runs (32 cycles)
//   HI      out  high product word / remainder
//   LO      out  low product word / quotient
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO are handled here
// RUN   | one iteration per cycle; HI/LO are written on the 32nd cycle
module mdu (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  // multiply: {partial product high, multiplier / product low}
  // divide:   {partial remainder, dividend / quotient}
  logic [63:0] work_q;
  logic [31:0] opb_q;      // multiplicand or divisor magnitude
  logic        neg_res_q;  // negate the product or quotient at completion

  logic        is_mul_op, launch, ld_sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] work_d, mul_prod;
  logic [31:0] res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic        div_q, neg_rem_q, bzero_q;
  logic [31:0] a_q;        // raw dividend; HI on divide by zero
  logic        is_div_op;
  logic [32:0] div_shift, div_diff;
`endif

  assign is_mul_op = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_DIV_EN
  assign is_div_op = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign launch    = is_mul_op || is_div_op;
`else
  assign launch    = is_mul_op;
`endif

  assign ld_sgn = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
  assign a_mag  = (ld_sgn && A[31]) ? (32'd0 - A) : A;
  assign b_mag  = (ld_sgn && B[31]) ? (32'd0 - B) : B;

  always_comb begin
    mul_sum = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
    work_d  = {mul_sum, work_q[31:1]};
`ifdef MDU_DIV_EN
    div_shift = {work_q[63:32], work_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_q) begin
      // A borrow in bit 32 means the divisor did not fit, so the shifted
      // remainder is kept (restored).
      if (div_diff[32]) work_d = {div_shift[31:0], work_q[30:0], 1'b0};
      else              work_d = {div_diff[31:0],  work_q[30:0], 1'b1};
    end
`endif
  end

  always_comb begin
    mul_prod = neg_res_q ? (64'd0 - work_d) : work_d;
    res_hi   = mul_prod[63:32];
    res_lo   = mul_prod[31:0];
`ifdef MDU_DIV_EN
    if (div_q) begin
      if (bzero_q) begin
        res_hi = a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = neg_res_q ? (32'd0 - work_d[31:0])  : work_d[31:0];
        res_hi = neg_rem_q ? (32'd0 - work_d[63:32]) : work_d[63:32];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      work_q    <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            if (launch) begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              neg_res_q <= ld_sgn && (A[31] ^ B[31]);
              opb_q     <= a_mag;
              work_q    <= {32'd0, b_mag};
`ifdef MDU_DIV_EN
              div_q     <= is_div_op;
              neg_rem_q <= ld_sgn && A[31];
              bzero_q   <= (B == 32'd0);
              a_q       <= A;
              if (is_div_op) begin
                opb_q  <= b_mag;
                work_q <= {32'd0, a_mag};
              end
`endif
            end else if (MDUOp == OP_MTHI) begin
              hi_q <= A;
            end else if (MDUOp == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              hi_q    <= res_hi;
              lo_q    <= res_lo;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        start, cancel;
  logic        busy;
  logic [31:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu dut (
    .clk(clk), .rstn(rstn), .A(A), .B(B), .MDUOp(MDUOp),
    .start(start), .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_iter(input logic [2:0] op);
`ifdef MDU_DIV_EN
    return (op >= 3'd1) && (op <= 3'd4);
`else
    return (op == 3'd1) || (op == 3'd2);
`endif
  endfunction

  // Expected {HI,LO} after op, from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint p;
    int sa, sb;
    logic [63:0] r;
    sa = int'(a);
    sb = int'(b);
    r  = {hi, lo};
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); r = 64'(p); end
      3'd2: r = {32'd0, a} * {32'd0, b};
`ifdef MDU_DIV_EN
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
`endif
      3'd5: r = {a, lo};
      3'd6: r = {hi, a};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int cyc;
    bit held;
    exp = model(op, a, b, hi_m, lo_m);
    @(negedge clk);
    MDUOp = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    if (!is_iter(op)) begin
      start = 1'b0;
      check("busy_single", 64'(busy), 64'd0);
      check("hilo_single", {HI, LO}, exp);
    end else begin
      check("busy_rise", 64'(busy), 64'd1);
      cyc  = 0;
      held = 1'b1;
      while (busy && cyc < 40) begin
        // Junk requests while running must all be ignored, including one
        // aimed at the completion edge.
        start = 1'b1;
        MDUOp = 3'($urandom_range(0, 7));
        A = $urandom;
        B = $urandom;
        if (cyc == 31) MDUOp = 3'd5;
        @(posedge clk); #1;
        cyc++;
        if (busy && (HI !== hi_m || LO !== lo_m)) held = 1'b0;
      end
      start = 1'b0;
      check("busy_len", 64'(cyc), 64'd32);
      check("hilo_hold", 64'(held), 64'd1);
      check("result", {HI, LO}, exp);
    end
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rstn = 1'b0; start = 1'b0; cancel = 1'b0; MDUOp = 3'd0; A = '0; B = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFD, 32'd7);
    check("mult_m3x7", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd5, 32'h1234_5678, 32'd0);
    check("mthi", 64'(HI), 64'h1234_5678);
    do_op(3'd6, 32'hCAFE_F00D, 32'd0);
    do_op(3'd0, 32'hDEAD_BEEF, 32'd1);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd1);
`ifdef MDU_DIV_EN
    do_op(3'd4, 32'd100, 32'd7);
    check("divu_100_7", {HI, LO}, {32'd2, 32'd14});
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(3'd3, 32'd5, 32'd0);
    check("div_5_0", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {HI, LO}, {32'd0, 32'h8000_0000});
    do_op(3'd3, 32'hFFFF_FF00, 32'd0);
    do_op(3'd4, 32'h8000_0001, 32'd0);
`else
    do_op(3'd3, 32'd9, 32'd3);
    check("div_disabled", {HI, LO}, {hi_m, lo_m});
    do_op(3'd4, 32'd9, 32'd3);
`endif

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      do_op(op, a, b);
    end

    // cancel on the 10th cycle of a multiply
    @(negedge clk);
    MDUOp = 3'd1; A = 32'd12345; B = 32'd678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hilo", {HI, LO}, {hi_m, lo_m});

    // cancel in IDLE beats a simultaneous start
    @(negedge clk);
    MDUOp = 3'd2; A = 32'd3; B = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_idle_busy", 64'(busy), 64'd0);
    MDUOp = 3'd5; A = 32'h5555_AAAA;
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
    check("cancel_idle_mthi", {HI, LO}, {hi_m, lo_m});

    do_op(3'd5, 32'hA5A5_0001, 32'd0);

    // asynchronous reset in the middle of an iterative op
    @(negedge clk);
`ifdef MDU_DIV_EN
    MDUOp = 3'd3;
`else
    MDUOp = 3'd1;
`endif
    A = 32'd1000; B = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    do_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
